// File: rtl/alu_op_sequencer_if.sv
// Bus between the fetch/ALU/register-file environment and the ALU op sequencer.
// The environment (master) offers instructions and returns ALU results; the
// sequencer (slave) steers the datapath and reports retirement.
interface alu_op_sequencer_if;
  logic [15:0] IR_In;
  logic        IR_Valid;
  logic        IR_Ready;
  logic [15:0] ALU_Out;
  logic [15:0] IR_Out;
  logic [2:0]  SR1_Addr;
  logic [2:0]  SR2_Addr;
  logic        SR2MUX_Control;
  logic [1:0]  ALUMUX_Control;
  logic [2:0]  DR_Addr;
  logic        RF_WE;
  logic [15:0] RF_Data;
  logic [2:0]  NZP;
  logic        Done;
  logic        Illegal;

  modport master (
    output IR_In, IR_Valid, ALU_Out,
    input  IR_Ready, IR_Out, SR1_Addr, SR2_Addr, SR2MUX_Control,
           ALUMUX_Control, DR_Addr, RF_WE, RF_Data, NZP, Done, Illegal
  );

  modport slave (
    input  IR_In, IR_Valid, ALU_Out,
    output IR_Ready, IR_Out, SR1_Addr, SR2_Addr, SR2MUX_Control,
           ALUMUX_Control, DR_Addr, RF_WE, RF_Data, NZP, Done, Illegal
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// ALU op sequencer: accepts ADD/AND/NOT instructions, steers the ALU muxes,
// captures the ALU result and writes it back while updating NZP.
// Four-state FSM IDLE -> DECODE -> EXEC -> WB; illegal opcodes return to IDLE
// from DECODE with a one-cycle Illegal pulse. All control outputs registered.
module alu_op_sequencer #(
  parameter logic [2:0] CC_RESET = 3'b010
) (
  input  logic               Clk,
  input  logic               Reset,
  alu_op_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_t;

  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_NOT = 4'b1001;

  state_t      state_q;
  logic [15:0] ir_q;
  logic [15:0] result_q;
  logic [2:0]  nzp_q;
  logic        ir_ready_q;
  logic        rf_we_q;
  logic        done_q;
  logic        illegal_q;
  logic        sr2mux_q;
  logic [1:0]  alumux_q;

  // NOT is only legal with the all-ones low field
  function automatic logic is_legal(input logic [3:0] op, input logic [5:0] low);
    case (op)
      OP_ADD, OP_AND: is_legal = 1'b1;
      OP_NOT:         is_legal = (low == 6'b111111);
      default:        is_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] alu_sel(input logic [3:0] op);
    case (op)
      OP_ADD:  alu_sel = 2'b00;
      OP_AND:  alu_sel = 2'b01;
      default: alu_sel = 2'b10;
    endcase
  endfunction

  function automatic logic [2:0] nzp_of(input logic [15:0] res);
    if (res[15])              nzp_of = 3'b100;
    else if (res == 16'h0000) nzp_of = 3'b010;
    else                      nzp_of = 3'b001;
  endfunction

  // Sequencer FSM with registered datapath controls and status pulses
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= IDLE;
      ir_q       <= 16'h0000;
      result_q   <= 16'h0000;
      nzp_q      <= CC_RESET;
      ir_ready_q <= 1'b1;
      rf_we_q    <= 1'b0;
      done_q     <= 1'b0;
      illegal_q  <= 1'b0;
      sr2mux_q   <= 1'b0;
      alumux_q   <= 2'b11;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.IR_Valid) begin
            // Legality is decided at acceptance so Illegal lands in DECODE
            ir_q       <= bus.IR_In;
            illegal_q  <= !is_legal(bus.IR_In[15:12], bus.IR_In[5:0]);
            ir_ready_q <= 1'b0;
            state_q    <= DECODE;
          end
        end
        DECODE: begin
          illegal_q <= 1'b0;
          if (is_legal(ir_q[15:12], ir_q[5:0])) begin
            alumux_q <= alu_sel(ir_q[15:12]);
            sr2mux_q <= (ir_q[15:12] != OP_NOT) && ir_q[5];
            state_q  <= EXEC;
          end else begin
            ir_ready_q <= 1'b1;
            state_q    <= IDLE;
          end
        end
        EXEC: begin
          result_q <= bus.ALU_Out;
          rf_we_q  <= 1'b1;
          done_q   <= 1'b1;
          state_q  <= WB;
        end
        WB: begin
          nzp_q      <= nzp_of(result_q);
          rf_we_q    <= 1'b0;
          done_q     <= 1'b0;
          alumux_q   <= 2'b11;
          sr2mux_q   <= 1'b0;
          ir_ready_q <= 1'b1;
          state_q    <= IDLE;
        end
        default: begin
          rf_we_q    <= 1'b0;
          done_q     <= 1'b0;
          illegal_q  <= 1'b0;
          alumux_q   <= 2'b11;
          sr2mux_q   <= 1'b0;
          ir_ready_q <= 1'b1;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign bus.IR_Ready       = ir_ready_q;
  assign bus.IR_Out         = ir_q;
  assign bus.SR1_Addr       = ir_q[8:6];
  assign bus.SR2_Addr       = ir_q[2:0];
  assign bus.DR_Addr        = ir_q[11:9];
  assign bus.SR2MUX_Control = sr2mux_q;
  assign bus.ALUMUX_Control = alumux_q;
  assign bus.RF_WE          = rf_we_q;
  assign bus.RF_Data        = result_q;
  assign bus.NZP            = nzp_q;
  assign bus.Done           = done_q;
  assign bus.Illegal        = illegal_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed self-checking bench for alu_op_sequencer. Inputs are driven and
// outputs sampled on the falling clock edge.
module tb_alu_op_sequencer;
  logic Clk;
  logic Reset;
  int   n_checks;
  int   n_fail;

  alu_op_sequencer_if bus();

  alu_op_sequencer #(.CC_RESET(3'b010)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic test_reset;
    Reset = 1'b1; bus.IR_Valid = 1'b1; bus.IR_In = 16'h12BD; bus.ALU_Out = 16'h0000;
    repeat (2) @(negedge Clk);
    n_checks++; if (bus.IR_Ready !== 1'b1) begin n_fail++; $display("FAIL reset_ir_ready got %b exp 1", bus.IR_Ready); end
    n_checks++; if (bus.RF_WE !== 1'b0) begin n_fail++; $display("FAIL reset_rf_we got %b exp 0", bus.RF_WE); end
    n_checks++; if (bus.Done !== 1'b0 || bus.Illegal !== 1'b0) begin n_fail++; $display("FAIL reset_pulses got done=%b ill=%b exp 0 0", bus.Done, bus.Illegal); end
    n_checks++; if (bus.ALUMUX_Control !== 2'b11) begin n_fail++; $display("FAIL reset_alumux got %b exp 11", bus.ALUMUX_Control); end
    n_checks++; if (bus.SR2MUX_Control !== 1'b0) begin n_fail++; $display("FAIL reset_sr2mux got %b exp 0", bus.SR2MUX_Control); end
    n_checks++; if (bus.NZP !== 3'b010) begin n_fail++; $display("FAIL reset_nzp got %b exp 010", bus.NZP); end
    n_checks++; if (bus.IR_Out !== 16'h0000) begin n_fail++; $display("FAIL reset_ir_out got %h exp 0000", bus.IR_Out); end
    Reset = 1'b0; bus.IR_Valid = 1'b0;
  endtask

  task automatic test_add;
    // ADD R1,R2,#-3 ; ALU returns 0xFFFE
    bus.IR_In = 16'h12BD; bus.IR_Valid = 1'b1; bus.ALU_Out = 16'hFFFE;
    n_checks++; if (bus.IR_Ready !== 1'b1) begin n_fail++; $display("FAIL add_idle_ready got %b exp 1", bus.IR_Ready); end
    @(negedge Clk); bus.IR_Valid = 1'b0;            // DECODE
    n_checks++; if (bus.IR_Ready !== 1'b0 || bus.ALUMUX_Control !== 2'b11 || bus.Illegal !== 1'b0) begin n_fail++; $display("FAIL add_decode got rdy=%b mux=%b ill=%b exp 0 11 0", bus.IR_Ready, bus.ALUMUX_Control, bus.Illegal); end
    n_checks++; if (bus.IR_Out !== 16'h12BD) begin n_fail++; $display("FAIL add_ir_out got %h exp 12bd", bus.IR_Out); end
    @(negedge Clk);                                 // EXEC
    n_checks++; if (bus.ALUMUX_Control !== 2'b00 || bus.SR2MUX_Control !== 1'b1 || bus.RF_WE !== 1'b0) begin n_fail++; $display("FAIL add_exec got mux=%b sr2=%b we=%b exp 00 1 0", bus.ALUMUX_Control, bus.SR2MUX_Control, bus.RF_WE); end
    @(negedge Clk);                                 // WB (T+3)
    n_checks++; if (bus.RF_WE !== 1'b1 || bus.Done !== 1'b1) begin n_fail++; $display("FAIL add_wb_we got we=%b done=%b exp 1 1", bus.RF_WE, bus.Done); end
    n_checks++; if (bus.RF_Data !== 16'hFFFE || bus.DR_Addr !== 3'd1) begin n_fail++; $display("FAIL add_wb_data got %h dr=%0d exp fffe 1", bus.RF_Data, bus.DR_Addr); end
    n_checks++; if (bus.SR1_Addr !== 3'd2 || bus.SR2_Addr !== 3'd5) begin n_fail++; $display("FAIL add_src got sr1=%0d sr2=%0d exp 2 5", bus.SR1_Addr, bus.SR2_Addr); end
    n_checks++; if (bus.SR2MUX_Control !== 1'b1 || bus.ALUMUX_Control !== 2'b00) begin n_fail++; $display("FAIL add_wb_mux got sr2=%b mux=%b exp 1 00", bus.SR2MUX_Control, bus.ALUMUX_Control); end
    @(negedge Clk);                                 // IDLE
    n_checks++; if (bus.NZP !== 3'b100) begin n_fail++; $display("FAIL add_nzp got %b exp 100", bus.NZP); end
    n_checks++; if (bus.RF_WE !== 1'b0 || bus.Done !== 1'b0 || bus.IR_Ready !== 1'b1 || bus.ALUMUX_Control !== 2'b11) begin n_fail++; $display("FAIL add_after got we=%b done=%b rdy=%b mux=%b exp 0 0 1 11", bus.RF_WE, bus.Done, bus.IR_Ready, bus.ALUMUX_Control); end
  endtask

  task automatic test_and;
    // AND R3,R4,R5 ; ALU returns 0
    bus.IR_In = 16'h5705; bus.IR_Valid = 1'b1; bus.ALU_Out = 16'h0000;
    @(negedge Clk); bus.IR_Valid = 1'b0;
    @(negedge Clk);                                 // EXEC
    n_checks++; if (bus.ALUMUX_Control !== 2'b01 || bus.SR2MUX_Control !== 1'b0) begin n_fail++; $display("FAIL and_exec got mux=%b sr2=%b exp 01 0", bus.ALUMUX_Control, bus.SR2MUX_Control); end
    @(negedge Clk);                                 // WB
    n_checks++; if (bus.Done !== 1'b1 || bus.DR_Addr !== 3'd3 || bus.SR1_Addr !== 3'd4 || bus.RF_Data !== 16'h0000) begin n_fail++; $display("FAIL and_wb got done=%b dr=%0d sr1=%0d data=%h exp 1 3 4 0000", bus.Done, bus.DR_Addr, bus.SR1_Addr, bus.RF_Data); end
    @(negedge Clk);
    n_checks++; if (bus.NZP !== 3'b010 || bus.Done !== 1'b0) begin n_fail++; $display("FAIL and_nzp got nzp=%b done=%b exp 010 0", bus.NZP, bus.Done); end
  endtask

  task automatic test_not;
    // NOT R6,R7 ; ALU returns 0x00F0
    bus.IR_In = 16'h9DFF; bus.IR_Valid = 1'b1; bus.ALU_Out = 16'h00F0;
    @(negedge Clk); bus.IR_Valid = 1'b0;
    n_checks++; if (bus.Illegal !== 1'b0) begin n_fail++; $display("FAIL not_legal got ill=%b exp 0", bus.Illegal); end
    @(negedge Clk);                                 // EXEC
    n_checks++; if (bus.ALUMUX_Control !== 2'b10 || bus.SR2MUX_Control !== 1'b0) begin n_fail++; $display("FAIL not_exec got mux=%b sr2=%b exp 10 0", bus.ALUMUX_Control, bus.SR2MUX_Control); end
    @(negedge Clk);                                 // WB
    n_checks++; if (bus.RF_WE !== 1'b1 || bus.SR1_Addr !== 3'd7 || bus.DR_Addr !== 3'd6 || bus.RF_Data !== 16'h00F0) begin n_fail++; $display("FAIL not_wb got we=%b sr1=%0d dr=%0d data=%h exp 1 7 6 00f0", bus.RF_WE, bus.SR1_Addr, bus.DR_Addr, bus.RF_Data); end
    @(negedge Clk);
    n_checks++; if (bus.NZP !== 3'b001) begin n_fail++; $display("FAIL not_nzp got %b exp 001", bus.NZP); end
  endtask

  task automatic test_illegal;
    logic [15:0] bad [2];
    int we_seen;
    bad[0] = 16'h993E; bad[1] = 16'h0000;
    for (int k = 0; k < 2; k++) begin
      we_seen = 0;
      bus.IR_In = bad[k]; bus.IR_Valid = 1'b1; bus.ALU_Out = 16'h8000;
      @(negedge Clk); bus.IR_Valid = 1'b0;          // DECODE
      if (bus.RF_WE === 1'b1) we_seen++;
      n_checks++; if (bus.Illegal !== 1'b1 || bus.IR_Ready !== 1'b0) begin n_fail++; $display("FAIL illegal_pulse ir=%h got ill=%b rdy=%b exp 1 0", bad[k], bus.Illegal, bus.IR_Ready); end
      @(negedge Clk);                               // back in IDLE
      if (bus.RF_WE === 1'b1) we_seen++;
      n_checks++; if (bus.Illegal !== 1'b0 || bus.IR_Ready !== 1'b1) begin n_fail++; $display("FAIL illegal_return ir=%h got ill=%b rdy=%b exp 0 1", bad[k], bus.Illegal, bus.IR_Ready); end
      @(negedge Clk);
      if (bus.RF_WE === 1'b1) we_seen++;
      n_checks++; if (we_seen !== 0 || bus.NZP !== 3'b001) begin n_fail++; $display("FAIL illegal_nowrite ir=%h got we_seen=%0d nzp=%b exp 0 001", bad[k], we_seen, bus.NZP); end
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] done_seen;
    done_seen = 8'h00;
    // IR_Valid held high; a new instruction is offered while the first is busy
    bus.IR_In = 16'h12BD; bus.IR_Valid = 1'b1; bus.ALU_Out = 16'h0005;
    for (int c = 0; c < 8; c++) begin
      @(negedge Clk);
      done_seen[c] = bus.Done;
      if (c == 0) bus.IR_In = 16'h5705;
      if (c == 1) begin
        n_checks++; if (bus.IR_Out !== 16'h12BD) begin n_fail++; $display("FAIL b2b_ignore got %h exp 12bd", bus.IR_Out); end
      end
      if (c == 4) begin
        n_checks++; if (bus.IR_Out !== 16'h5705) begin n_fail++; $display("FAIL b2b_second got %h exp 5705", bus.IR_Out); end
      end
    end
    bus.IR_Valid = 1'b0;
    n_checks++; if (done_seen !== 8'b0100_0100) begin n_fail++; $display("FAIL b2b_done_cadence got %b exp 01000100", done_seen); end
    @(negedge Clk);                                 // IDLE after second retirement
    n_checks++; if (bus.NZP !== 3'b001 || bus.IR_Ready !== 1'b1) begin n_fail++; $display("FAIL b2b_end got nzp=%b rdy=%b exp 001 1", bus.NZP, bus.IR_Ready); end
  endtask

  task automatic test_reset_exec;
    bus.IR_In = 16'h12BD; bus.IR_Valid = 1'b1; bus.ALU_Out = 16'hFFFE;
    @(negedge Clk); bus.IR_Valid = 1'b0;            // DECODE
    @(negedge Clk); Reset = 1'b1; bus.IR_Valid = 1'b1; // EXEC, reset applied
    @(negedge Clk); Reset = 1'b0; bus.IR_Valid = 1'b0;
    n_checks++; if (bus.RF_WE !== 1'b0 || bus.Done !== 1'b0) begin n_fail++; $display("FAIL rst_exec_we got we=%b done=%b exp 0 0", bus.RF_WE, bus.Done); end
    n_checks++; if (bus.NZP !== 3'b010 || bus.IR_Ready !== 1'b1 || bus.IR_Out !== 16'h0000) begin n_fail++; $display("FAIL rst_exec_state got nzp=%b rdy=%b ir=%h exp 010 1 0000", bus.NZP, bus.IR_Ready, bus.IR_Out); end
    @(negedge Clk);
    n_checks++; if (bus.RF_WE !== 1'b0 || bus.RF_Data !== 16'h0000) begin n_fail++; $display("FAIL rst_exec_late got we=%b data=%h exp 0 0000", bus.RF_WE, bus.RF_Data); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    bus.IR_In = 16'h0000; bus.IR_Valid = 1'b0; bus.ALU_Out = 16'h0000; Reset = 1'b1;
    @(negedge Clk);
    test_reset();
    test_add();
    test_and();
    test_not();
    test_illegal();
    test_back_to_back();
    test_reset_exec();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 Parameter CC_RESET, default 3'b010, value loaded into NZP on reset (Z set).
REQ-002 Clk  input  1  sole clock; all state changes on rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 IR_In  input  16  instruction word offered by fetch logic.
REQ-005 IR_Valid  input  1  IR_In valid this cycle.
REQ-006 IR_Ready  output  1  sequencer can accept an instruction this cycle.
REQ-007 ALU_Out  input  16  combinational result returned by the ALU.
REQ-008 IR_Out  output  16  latched instruction driven to the ALU IR input.
REQ-009 SR1_Addr  output  3  register-file read port 1 address.
REQ-010 SR2_Addr  output  3  register-file read port 2 address.
REQ-011 SR2MUX_Control  output  1  ALU operand-2 select; 1 = sign-extended IR[4:0].
REQ-012 ALUMUX_Control  output  2  ALU function: 00 ADD, 01 AND, 10 NOT, 11 pass SR1.
REQ-013 DR_Addr  output  3  register-file write address.
REQ-014 RF_WE  output  1  register-file write enable.
REQ-015 RF_Data  output  16  register-file write data.
REQ-016 NZP  output  3  condition codes {N,Z,P}.
REQ-017 Done  output  1  one-cycle pulse on instruction retirement.
REQ-018 Illegal  output  1  one-cycle pulse on rejected instruction.

Function
REQ-019 FSM states SHALL be IDLE, DECODE, EXEC, WB; encoding free.
REQ-020 IDLE: IR_Ready=1; IR_Valid=1 latches IR_In into IR register and moves to DECODE; otherwise stays IDLE.
REQ-021 IR_Ready SHALL be 0 in DECODE, EXEC, WB; IR_Valid in those states ignored, IR register unchanged.
REQ-022 DECODE: opcode IR[15:12] = 0001 (ADD), 0101 (AND) -> EXEC; 1001 (NOT) with IR[5:0]=111111 -> EXEC; any other -> Illegal=1 for that cycle, next state IDLE, no write, NZP unchanged.
REQ-023 IR_Out SHALL equal the IR register in all states; SR1_Addr=IR[8:6], SR2_Addr=IR[2:0], DR_Addr=IR[11:9] continuously.
REQ-024 SR2MUX_Control SHALL equal IR[5] in EXEC and WB for ADD/AND; 0 for NOT and in IDLE/DECODE.
REQ-025 ALUMUX_Control SHALL be 00/01/10 for ADD/AND/NOT in EXEC and WB; 11 in IDLE and DECODE.
REQ-026 EXEC: ALU_Out captured into 16-bit result register at end of cycle; next state WB unconditionally.
REQ-027 WB: RF_WE=1, RF_Data=result register, Done=1, NZP updated at end of cycle, next state IDLE.
REQ-028 NZP update: 100 if result[15]=1; 010 if result=0; 001 otherwise; exactly one bit set.
REQ-029 RF_WE, Done, Illegal SHALL be 0 in all states other than those stated.
REQ-030 Latency: legal instruction accepted at edge T -> RF_WE/Done high in cycle T+3; next acceptance earliest at edge T+4; illegal -> next acceptance at edge T+2.
REQ-031 Arithmetic is performed solely by the ALU; 16-bit wrap-around, no carry/overflow flag.

Reset
REQ-032 Reset=1 at an edge SHALL force IDLE, IR register=0, result=0, NZP=CC_RESET, from any state.
REQ-033 Reset overrides IR_Valid; Reset in EXEC or WB SHALL suppress the pending write (RF_WE=0 next cycle, register file untouched).
REQ-034 After reset: IR_Ready=1, RF_WE=0, Done=0, Illegal=0, ALUMUX_Control=11, SR2MUX_Control=0.

Verification
REQ-035 ADD R1,R2,#-3 (IR=0x12BD), ALU_Out=0xFFFE -> cycle T+3: RF_WE=1, DR_Addr=1, RF_Data=0xFFFE, SR2MUX=1, ALUMUX=00; NZP=100 after.
REQ-036 AND R3,R4,R5 (IR=0x5705), ALU_Out=0x0000 -> SR2MUX=0, ALUMUX=01, DR_Addr=3, Done pulse; NZP=010.
REQ-037 NOT R6,R7 (IR=0x9DFF), ALU_Out=0x00F0 -> ALUMUX=10, SR1_Addr=7, DR_Addr=6; NZP=001.
REQ-038 IR=0x993E (NOT, IR[5:0]!=111111) and IR=0x0000 -> Illegal pulse in DECODE, RF_WE never asserted, NZP unchanged, IR_Ready high 2 cycles after accept.
REQ-039 IR_Valid held high with new IR during DECODE/EXEC/WB -> ignored; back-to-back instructions retire every 4 cycles.
REQ-040 Reset asserted during EXEC of ADD -> no RF_WE, NZP=010, IR_Ready=1 next cycle.
